soc_system_sysid_checker: RTL and testbench

Hardware self-check master for the system ID slave. On a start pulse or a periodic timer it reads the slave's two 32-bit words, ID at word address 0 and build timestamp at word address 1. It compares both against compile-time expected values and publishes pass/fail flags, the captured words and a saturating mismatch counter. It sits directly downstream of the sysid control slave and drives that slave's `address` input while consuming its `readdata`.

---
 rtl/soc_system_sysid_checker_if.sv | 12 +
 rtl/soc_system_sysid_checker.sv | 145 ++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_sysid_checker_if.sv
// Word-select / read-data link between the checker and the sysid control slave.
interface soc_system_sysid_checker_if;
    localparam int unsigned DATA_W = 32;

    logic              sysid_address;
    logic [DATA_W-1:0] sysid_readdata;

    // Checker side: drives the word select, consumes read data.
    modport master (output sysid_address, input sysid_readdata);
    // Slave side: decodes the word select, returns read data.
    modport slave  (input sysid_address, output sysid_readdata);
endinterface

// File: rtl/soc_system_sysid_checker.sv
// Self-check master for the system ID slave: reads ID and build timestamp on
// a start pulse or periodic timer, compares them with expected constants and
// publishes registered pass/fail flags, captured words and a mismatch count.
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd2899645186,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1460819638,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned RECHECK_PERIOD     = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              clear_err,
    soc_system_sysid_checker_if.master        sysid,
    output logic                              busy,
    output logic                              done,
    output logic                              result_valid,
    output logic                              id_ok,
    output logic                              ts_ok,
    output logic [31:0]                       captured_id,
    output logic [31:0]                       captured_ts,
    output logic [7:0]                        err_count
);

    localparam int unsigned WAIT_W   = 2;
    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned ERR_W    = 8;

    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(READ_LATENCY);
    localparam bit                  PERIOD_EN   = (RECHECK_PERIOD > 0);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST =
        PERIOD_EN ? PERIOD_W'(RECHECK_PERIOD - 1) : '0;
    localparam logic [ERR_W-1:0]    ERR_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_hit_c;
    logic                cap_id_c;
    logic                cap_ts_c;
    logic                mismatch_c;
    logic                address_q;

    assign period_hit_c = PERIOD_EN && (period_q == PERIOD_LAST);

    // Either compare failing at completion; id uses the word captured in RD_ID.
    assign mismatch_c = (captured_id != EXPECTED_ID) ||
                        (sysid.sysid_readdata != EXPECTED_TIMESTAMP);

    assign sysid.sysid_address = address_q;

    // Next-state, latency wait counter and idle period counter.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        period_d = '0;
        cap_id_c = 1'b0;
        cap_ts_c = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (start || period_hit_c) begin
                    state_d = RD_ID;
                end else if (PERIOD_EN) begin
                    period_d = period_q + PERIOD_W'(1);
                end
            end
            RD_ID: begin
                if (wait_q == WAIT_LAST) begin
                    cap_id_c = 1'b1;
                    wait_d   = '0;
                    state_d  = RD_TS;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RD_TS: begin
                if (wait_q == WAIT_LAST) begin
                    cap_ts_c = 1'b1;
                    wait_d   = '0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // FSM state, wait counter and period counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            period_q <= period_d;
        end
    end

    // Registered outputs, derived from the next state so busy/address align with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            captured_id  <= '0;
            captured_ts  <= '0;
            err_count    <= '0;
        end else begin
            address_q <= (state_d == RD_TS);
            busy      <= (state_d != IDLE);
            done      <= cap_ts_c;
            if (cap_id_c) begin
                captured_id <= sysid.sysid_readdata;
            end
            if (cap_ts_c) begin
                captured_ts  <= sysid.sysid_readdata;
                id_ok        <= (captured_id == EXPECTED_ID);
                ts_ok        <= (sysid.sysid_readdata == EXPECTED_TIMESTAMP);
                result_valid <= 1'b1;
            end
            if (clear_err) begin
                err_count <= '0;
            end else if (cap_ts_c && mismatch_c && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Bench for soc_system_sysid_checker: three instances (L=0, L=2, L=1 with a
// 10-cycle recheck period) each fed by a latency-aware sysid slave model.
module tb_soc_system_sysid_checker;

    localparam logic [31:0] EID = 32'd2899645186;
    localparam logic [31:0] ETS = 32'd1460819638;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [2:0]        start_v;
    logic [2:0]        clr_v;
    logic [2:0][31:0]  rd_v;
    wire  [2:0]        done_v, busy_v, rv_v, idok_v, tsok_v, addr_v;
    wire  [2:0][31:0]  cid_v, cts_v;
    wire  [2:0][7:0]   err_v;

    soc_system_sysid_checker_if bus0 ();
    soc_system_sysid_checker_if bus1 ();
    soc_system_sysid_checker_if bus2 ();

    assign bus0.sysid_readdata = rd_v[0];
    assign bus1.sysid_readdata = rd_v[1];
    assign bus2.sysid_readdata = rd_v[2];
    assign addr_v[0] = bus0.sysid_address;
    assign addr_v[1] = bus1.sysid_address;
    assign addr_v[2] = bus2.sysid_address;

    soc_system_sysid_checker #(.READ_LATENCY(0), .RECHECK_PERIOD(0)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .clear_err(clr_v[0]),
        .sysid(bus0), .busy(busy_v[0]), .done(done_v[0]), .result_valid(rv_v[0]),
        .id_ok(idok_v[0]), .ts_ok(tsok_v[0]), .captured_id(cid_v[0]),
        .captured_ts(cts_v[0]), .err_count(err_v[0]));

    soc_system_sysid_checker #(.READ_LATENCY(2), .RECHECK_PERIOD(0)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .clear_err(clr_v[1]),
        .sysid(bus1), .busy(busy_v[1]), .done(done_v[1]), .result_valid(rv_v[1]),
        .id_ok(idok_v[1]), .ts_ok(tsok_v[1]), .captured_id(cid_v[1]),
        .captured_ts(cts_v[1]), .err_count(err_v[1]));

    soc_system_sysid_checker #(.READ_LATENCY(1), .RECHECK_PERIOD(10)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .clear_err(clr_v[2]),
        .sysid(bus2), .busy(busy_v[2]), .done(done_v[2]), .result_valid(rv_v[2]),
        .id_ok(idok_v[2]), .ts_ok(tsok_v[2]), .captured_id(cid_v[2]),
        .captured_ts(cts_v[2]), .err_count(err_v[2]));

    int total = 0;
    int bad   = 0;

    // Slave contents and model state
    logic [31:0] w0 [3];
    logic [31:0] w1 [3];
    int          stable [3];
    logic        prev_addr [3];
    int          model_err [3];

    function automatic int lat_of(input int k);
        if (k == 1) return 2;
        if (k == 2) return 1;
        return 0;
    endfunction

    function automatic int err_next(input int e, input bit mism, input bit clr);
        if (clr) return 0;
        if (mism && e < 255) return e + 1;
        return e;
    endfunction

    // Address pattern seen while busy: L+1 cycles of word 0 then L+1 of word 1.
    function automatic logic [15:0] exp_aseq(input int l);
        logic [15:0] v = '0;
        for (int j = l + 1; j <= 2 * l + 1; j++) v[j] = 1'b1;
        return v;
    endfunction

    // Slave model: data valid only once the address has been stable L cycles,
    // otherwise random garbage so premature captures are exposed.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (addr_v[k] !== prev_addr[k]) stable[k] = 0;
            else if (stable[k] < 1000) stable[k] = stable[k] + 1;
            prev_addr[k] = addr_v[k];
            if (stable[k] >= lat_of(k)) rd_v[k] = addr_v[k] ? w1[k] : w0[k];
            else rd_v[k] = $urandom;
        end
    end

    // Pulse start on instance k (caller at a negedge); returns done latency in
    // negedges, busy cycles and the address sampled in each busy cycle.
    task automatic run(input int k, input int clr_at, output int lat,
                       output int nbusy, output logic [15:0] aseq);
        lat = -1; nbusy = 0; aseq = '0;
        start_v[k] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            start_v[k] = 1'b0;
            clr_v[k] = (i == clr_at);
            if (busy_v[k] && nbusy < 16) begin
                aseq[nbusy] = addr_v[k];
                nbusy++;
            end
            if (done_v[k]) begin
                lat = i;
                break;
            end
        end
        clr_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input bit pulse, output int n);
        bit pulsed = 1'b0;
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            start_v[k] = 1'b0;
            if (done_v[k]) begin
                n = i;
                break;
            end
            if (pulse && !pulsed && busy_v[k]) begin
                start_v[k] = 1'b1;
                pulsed = 1'b1;
            end
        end
        start_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({busy_v[k], done_v[k], rv_v[k], idok_v[k], tsok_v[k], addr_v[k],
                 cid_v[k], cts_v[k], err_v[k]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b rv=%b id_ok=%b ts_ok=%b addr=%b cid=%h cts=%h err=%0d want all zero",
                         k, busy_v[k], done_v[k], rv_v[k], idok_v[k], tsok_v[k], addr_v[k],
                         cid_v[k], cts_v[k], err_v[k]);
            end
            model_err[k] = 0;
        end
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (busy_v[0] !== 1'b0 || rv_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got busy=%b rv=%b want 0 0", busy_v[0], rv_v[0]);
        end
    endtask

    task automatic test_basic();
        int lat, nb; logic [15:0] aseq;
        w0[0] = EID; w1[0] = ETS;
        run(0, -1, lat, nb, aseq);
        model_err[0] = err_next(model_err[0], 1'b0, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL basic_done_latency: got %0d want 3", lat); end
        total++; if (nb !== 2) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 2", nb); end
        total++; if (aseq !== exp_aseq(0)) begin bad++; $display("FAIL basic_addr_seq: got %b want %b", aseq, exp_aseq(0)); end
        total++;
        if ({rv_v[0], idok_v[0], tsok_v[0]} !== 3'b111) begin
            bad++; $display("FAIL basic_flags: got rv/id/ts=%b want 111", {rv_v[0], idok_v[0], tsok_v[0]});
        end
        total++; if (err_v[0] !== 8'(model_err[0])) begin bad++; $display("FAIL basic_err: got %0d want %0d", err_v[0], model_err[0]); end
        total++; if (cid_v[0] !== EID || cts_v[0] !== ETS) begin bad++; $display("FAIL basic_captured: got %h/%h want %h/%h", cid_v[0], cts_v[0], EID, ETS); end
    endtask

    task automatic test_mismatch();
        int lat, nb; logic [15:0] aseq;
        bit mism;
        for (int r = 0; r < 2; r++) begin
            w0[0] = 32'h12345678; w1[0] = ETS;
            run(0, -1, lat, nb, aseq);
            model_err[0] = err_next(model_err[0], 1'b1, 1'b0);
            total++;
            if ({idok_v[0], tsok_v[0]} !== 2'b01) begin
                bad++; $display("FAIL mismatch_flags[%0d]: got id/ts=%b want 01", r, {idok_v[0], tsok_v[0]});
            end
            total++; if (cid_v[0] !== 32'h12345678) begin bad++; $display("FAIL mismatch_cid[%0d]: got %h want 12345678", r, cid_v[0]); end
            total++; if (err_v[0] !== 8'(r + 1)) begin bad++; $display("FAIL mismatch_err[%0d]: got %0d want %0d", r, err_v[0], r + 1); end
        end
        for (int r = 0; r < 6; r++) begin
            w0[0] = ($urandom_range(0, 1) == 1) ? EID : $urandom;
            w1[0] = ($urandom_range(0, 1) == 1) ? ETS : $urandom;
            mism = (w0[0] != EID) || (w1[0] != ETS);
            run(0, -1, lat, nb, aseq);
            model_err[0] = err_next(model_err[0], mism, 1'b0);
            total++;
            if ({idok_v[0], tsok_v[0], cid_v[0], cts_v[0], err_v[0]} !==
                {w0[0] == EID, w1[0] == ETS, w0[0], w1[0], 8'(model_err[0])}) begin
                bad++;
                $display("FAIL random_check[%0d]: got id=%b ts=%b cid=%h cts=%h err=%0d want id=%b ts=%b cid=%h cts=%h err=%0d",
                         r, idok_v[0], tsok_v[0], cid_v[0], cts_v[0], err_v[0],
                         w0[0] == EID, w1[0] == ETS, w0[0], w1[0], model_err[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, nb; logic [15:0] aseq;
        w0[0] = EID; w1[0] = ETS;
        run(0, -1, lat1, nb, aseq);
        run(0, -1, lat2, nb, aseq);
        model_err[0] = err_next(model_err[0], 1'b0, 1'b0);
        model_err[0] = err_next(model_err[0], 1'b0, 1'b0);
        total++; if (lat1 !== 3) begin bad++; $display("FAIL b2b_first_latency: got %0d want 3", lat1); end
        total++; if (lat2 !== 3) begin bad++; $display("FAIL b2b_second_latency: got %0d want 3", lat2); end
    endtask

    task automatic test_latency();
        int lat, nb; logic [15:0] aseq;
        bit mism;
        for (int r = 0; r < 6; r++) begin
            w0[1] = ($urandom_range(0, 1) == 1) ? EID : $urandom;
            w1[1] = ($urandom_range(0, 1) == 1) ? ETS : $urandom;
            mism = (w0[1] != EID) || (w1[1] != ETS);
            @(negedge clock);
            run(1, -1, lat, nb, aseq);
            model_err[1] = err_next(model_err[1], mism, 1'b0);
            total++; if (lat !== 7) begin bad++; $display("FAIL lat2_done[%0d]: got %0d want 7", r, lat); end
            total++; if (nb !== 6) begin bad++; $display("FAIL lat2_busy[%0d]: got %0d want 6", r, nb); end
            total++; if (aseq !== exp_aseq(2)) begin bad++; $display("FAIL lat2_addr_seq[%0d]: got %b want %b", r, aseq, exp_aseq(2)); end
            total++;
            if ({idok_v[1], tsok_v[1], cid_v[1], cts_v[1], err_v[1]} !==
                {w0[1] == EID, w1[1] == ETS, w0[1], w1[1], 8'(model_err[1])}) begin
                bad++;
                $display("FAIL lat2_result[%0d]: got id=%b ts=%b cid=%h cts=%h err=%0d want id=%b ts=%b cid=%h cts=%h err=%0d",
                         r, idok_v[1], tsok_v[1], cid_v[1], cts_v[1], err_v[1],
                         w0[1] == EID, w1[1] == ETS, w0[1], w1[1], model_err[1]);
            end
        end
    endtask

    task automatic test_period();
        int n;
        wait_done(2, 1'b0, n);
        total++; if (n < 0) begin bad++; $display("FAIL period_first_done: got timeout want a done"); end
        wait_done(2, 1'b0, n);
        total++; if (n !== 14) begin bad++; $display("FAIL period_interval: got %0d want 14", n); end
        wait_done(2, 1'b1, n);
        total++; if (n !== 14) begin bad++; $display("FAIL period_start_while_busy: got %0d want 14", n); end
        wait_done(2, 1'b0, n);
        total++; if (n !== 14) begin bad++; $display("FAIL period_no_queued_start: got %0d want 14", n); end
    endtask

    task automatic test_saturation();
        int lat, nb; logic [15:0] aseq;
        w0[0] = 32'hDEAD0000; w1[0] = ETS;
        while (model_err[0] < 255) begin
            run(0, -1, lat, nb, aseq);
            model_err[0] = err_next(model_err[0], 1'b1, 1'b0);
        end
        total++; if (err_v[0] !== 8'd255) begin bad++; $display("FAIL sat_reach: got %0d want 255", err_v[0]); end
        run(0, -1, lat, nb, aseq);
        model_err[0] = err_next(model_err[0], 1'b1, 1'b0);
        total++; if (err_v[0] !== 8'(model_err[0])) begin bad++; $display("FAIL sat_hold: got %0d want %0d", err_v[0], model_err[0]); end
        run(0, 2, lat, nb, aseq);
        model_err[0] = err_next(model_err[0], 1'b1, 1'b1);
        total++; if (lat !== 3) begin bad++; $display("FAIL clear_coincide_done: got %0d want 3", lat); end
        total++; if (err_v[0] !== 8'(model_err[0])) begin bad++; $display("FAIL clear_wins: got %0d want %0d", err_v[0], model_err[0]); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, ndone; logic [15:0] aseq;
        bit reached = 1'b0;
        w0[1] = EID; w1[1] = ETS;
        @(negedge clock);
        start_v[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            start_v[1] = 1'b0;
            if (addr_v[1] === 1'b1) begin
                reached = 1'b1;
                break;
            end
        end
        start_v[1] = 1'b0;
        total++; if (!reached || busy_v[1] !== 1'b1) begin bad++; $display("FAIL midreset_reach_rd_ts: got reached=%b busy=%b want 1 1", reached, busy_v[1]); end
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy_v[1], done_v[1], rv_v[1], idok_v[1], tsok_v[1], addr_v[1],
             cid_v[1], cts_v[1], err_v[1]} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got busy=%b done=%b rv=%b id=%b ts=%b addr=%b cid=%h cts=%h err=%0d want all zero",
                     busy_v[1], done_v[1], rv_v[1], idok_v[1], tsok_v[1], addr_v[1],
                     cid_v[1], cts_v[1], err_v[1]);
        end
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done_v[1] === 1'b1) ndone++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) model_err[k] = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done_v[1] === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d dones want 0", ndone); end
        run(1, -1, lat, nb, aseq);
        total++; if (lat !== 7) begin bad++; $display("FAIL midreset_recheck_latency: got %0d want 7", lat); end
        total++;
        if ({rv_v[1], idok_v[1], tsok_v[1], err_v[1]} !== {3'b111, 8'(model_err[1])}) begin
            bad++; $display("FAIL midreset_recheck_result: got rv/id/ts=%b err=%0d want 111 err=%0d",
                            {rv_v[1], idok_v[1], tsok_v[1]}, err_v[1], model_err[1]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_v = '0;
        clr_v   = '0;
        for (int k = 0; k < 3; k++) begin
            w0[k] = EID;
            w1[k] = ETS;
            stable[k] = 0;
            prev_addr[k] = 1'b0;
            model_err[k] = 0;
        end
        test_reset();
        test_basic();
        test_mismatch();
        test_back_to_back();
        test_latency();
        test_period();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
